product_accumulator: RTL and testbench

- Downstream consumer of the combinational 8x8 multiplier's 16-bit product `z`.
- Sums a group of products, delimited by `in_last`, into a wider accumulator. Presents the group sum with a valid/ready handshake.
- Forms the accumulate half of a multiply-accumulate path (dot products, FIR taps).

---
 rtl/product_acc_pkg.sv | 16 +
 rtl/acc_add.sv | 32 +++
 rtl/product_accumulator.sv | 108 ++++++++++
 tb/tb_product_accumulator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator.
// The optional saturating build is selected with PRODUCT_ACC_SATURATE_EN.
package product_acc_pkg;

   localparam int IN_W  = 16;
   localparam int ACC_W = 24;
   localparam int CNT_W = 8;

   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

   typedef enum logic {
      ACC,
      HOLD
   } acc_state_e;

endpackage

// File: rtl/acc_add.sv
// Adds a zero-extended product to the running sum and reports the carry out.
// With PRODUCT_ACC_SATURATE_EN defined the sum clamps at the all-ones value.
module acc_add
   import product_acc_pkg::*;
#(
   parameter int IN_W  = product_acc_pkg::IN_W,
   parameter int ACC_W = product_acc_pkg::ACC_W
) (
   input  logic [ACC_W-1:0] acc_in,
   input  logic [IN_W-1:0]  prod_in,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] nxt;

   assign nxt   = {1'b0, acc_in} + {{(ACC_W + 1 - IN_W){1'b0}}, prod_in};
   assign carry = nxt[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once the sum has pinned at the top it stays there for the rest of the group.
   always_comb begin
      sum = nxt[ACC_W-1:0];
      if (carry || (acc_in == {ACC_W{1'b1}})) begin
         sum = {ACC_W{1'b1}};
      end
   end
`else
   assign sum = nxt[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of multiplier products delimited by in_last and hands each group
// total downstream over a valid/ready handshake. Build option: PRODUCT_ACC_SATURATE_EN.
module product_accumulator
   import product_acc_pkg::*;
#(
   parameter int IN_W  = product_acc_pkg::IN_W,
   parameter int ACC_W = product_acc_pkg::ACC_W,
   parameter int CNT_W = product_acc_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_CLOSE = {{(CNT_W-1){1'b1}}, 1'b0};

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_carry;

   acc_add #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_acc_add (
      .acc_in  (acc_q),
      .prod_in (in_prod),
      .sum     (add_sum),
      .carry   (add_carry)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         ACC: begin
            if (in_valid) begin
               acc_d = add_sum;
               cnt_d = cnt_q + CNT_ONE;
               ovf_d = ovf_q | add_carry;
               // A full counter forces the group closed even without in_last.
               if (in_last || (cnt_q == CNT_CLOSE)) begin
                  out_sum_d   = add_sum;
                  out_count_d = cnt_q + CNT_ONE;
                  out_ovf_d   = ovf_q | add_carry;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACC;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator, built with ACC_W=18 so
// the overflow group wraps (or clamps under PRODUCT_ACC_SATURATE_EN).
module tb_product_accumulator;

   localparam int IN_W  = 16;
   localparam int ACC_W = 18;
   localparam int CNT_W = 8;

`ifdef PRODUCT_ACC_SATURATE_EN
   localparam int OVF_SUM = 262143;
`else
   localparam int OVF_SUM = 62981;
`endif

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [IN_W-1:0]  inProd = '0;
   logic             inLast = 1'b0;
   logic             outValid;
   logic             outReady = 1'b1;
   logic [ACC_W-1:0] outSum;
   logic [CNT_W-1:0] outCount;
   logic             outOvf;

   int errorCount = 0;
   int checkCount = 0;

   product_accumulator #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_prod   (inProd),
      .in_last   (inLast),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_sum   (outSum),
      .out_count (outCount),
      .out_ovf   (outOvf)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat, holding it until the block accepts it, then drop in_valid.
   task automatic applyStimulus(input int prod, input logic last);
      int waitCycles;
      waitCycles = 0;
      inValid = 1'b1;
      inProd  = IN_W'(prod);
      inLast  = last;
      while (!inReady && waitCycles < 50) begin
         tick();
         waitCycles++;
      end
      if (!inReady) checkOutput("beat_accept_timeout", 0, 1);
      tick();
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      tick();
      tick();
      checkOutput("rst_out_valid", int'(outValid), 0);
      checkOutput("rst_out_sum", int'(outSum), 0);
      checkOutput("rst_out_count", int'(outCount), 0);
      checkOutput("rst_out_ovf", int'(outOvf), 0);
      rstN = 1'b1;
      tick();
      checkOutput("rst_in_ready", int'(inReady), 1);

      // Basic group 20+40+80+100
      outReady = 1'b1;
      applyStimulus(20, 1'b0);
      applyStimulus(40, 1'b0);
      applyStimulus(80, 1'b0);
      checkOutput("basic_no_valid_yet", int'(outValid), 0);
      applyStimulus(100, 1'b1);
      checkOutput("basic_valid", int'(outValid), 1);
      checkOutput("basic_sum", int'(outSum), 240);
      checkOutput("basic_count", int'(outCount), 4);
      checkOutput("basic_ovf", int'(outOvf), 0);
      checkOutput("basic_in_ready_low", int'(inReady), 0);
      tick();
      checkOutput("basic_valid_drop", int'(outValid), 0);
      checkOutput("basic_in_ready_back", int'(inReady), 1);

      // Backpressure: result held while out_ready is low, extra beats ignored
      outReady = 1'b0;
      applyStimulus(20, 1'b0);
      applyStimulus(40, 1'b0);
      applyStimulus(80, 1'b0);
      applyStimulus(100, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid", int'(outValid), 1);
         checkOutput("bp_sum", int'(outSum), 240);
         checkOutput("bp_count", int'(outCount), 4);
         checkOutput("bp_in_ready", int'(inReady), 0);
         inValid = 1'b1;
         inProd  = 16'd999;
         inLast  = 1'b1;
         tick();
      end
      checkOutput("bp_sum_after", int'(outSum), 240);
      inValid = 1'b0;
      inLast  = 1'b0;
      outReady = 1'b1;
      tick();
      checkOutput("bp_release_valid", int'(outValid), 0);
      applyStimulus(10, 1'b1);
      checkOutput("bp_next_sum", int'(outSum), 10);
      checkOutput("bp_next_count", int'(outCount), 1);
      tick();

      // Overflow: five beats of 65025 into an 18-bit accumulator
      for (int i = 0; i < 4; i++) applyStimulus(65025, 1'b0);
      applyStimulus(65025, 1'b1);
      checkOutput("ovf_valid", int'(outValid), 1);
      checkOutput("ovf_sum", int'(outSum), OVF_SUM);
      checkOutput("ovf_count", int'(outCount), 5);
      checkOutput("ovf_flag", int'(outOvf), 1);
      tick();

      // Forced close after 255 beats without in_last
      for (int i = 0; i < 254; i++) applyStimulus(1, 1'b0);
      checkOutput("force_not_closed", int'(outValid), 0);
      applyStimulus(1, 1'b0);
      checkOutput("force_valid", int'(outValid), 1);
      checkOutput("force_sum", int'(outSum), 255);
      checkOutput("force_count", int'(outCount), 255);
      checkOutput("force_ovf", int'(outOvf), 0);
      tick();

      // Reset in the middle of a group discards it at once
      applyStimulus(20, 1'b0);
      applyStimulus(40, 1'b0);
      applyStimulus(80, 1'b0);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_sum", int'(outSum), 0);
      checkOutput("midrst_count", int'(outCount), 0);
      checkOutput("midrst_valid", int'(outValid), 0);
      checkOutput("midrst_ovf", int'(outOvf), 0);
      tick();
      tick();
      rstN = 1'b1;
      tick();
      applyStimulus(10, 1'b1);
      checkOutput("midrst_next_sum", int'(outSum), 10);
      checkOutput("midrst_next_count", int'(outCount), 1);
      tick();

      // Back-to-back groups with in_valid held high
      inValid = 1'b1;
      inProd  = 16'd20;
      inLast  = 1'b1;
      tick();
      checkOutput("b2b_first_valid", int'(outValid), 1);
      checkOutput("b2b_first_sum", int'(outSum), 20);
      checkOutput("b2b_bubble", int'(inReady), 0);
      inProd = 16'd40;
      inLast = 1'b0;
      tick();
      checkOutput("b2b_ready_after_bubble", int'(inReady), 1);
      checkOutput("b2b_valid_cleared", int'(outValid), 0);
      tick();
      checkOutput("b2b_mid_valid", int'(outValid), 0);
      inProd = 16'd80;
      inLast = 1'b1;
      tick();
      inValid = 1'b0;
      inLast  = 1'b0;
      checkOutput("b2b_second_valid", int'(outValid), 1);
      checkOutput("b2b_second_sum", int'(outSum), 120);
      checkOutput("b2b_second_count", int'(outCount), 2);
      tick();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
